seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 115 +++++++++++
 tb/tb_seq_multiplier.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Sequential 32x32->64 multiplier, signed/unsigned, N-cycle stall protocol.
// Define MUL_RADIX4_EN for radix-4 Booth (16 steps); default is radix-2 (32 steps).
module seq_multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        u,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic        stall,
  output logic [63:0] z
);

`ifdef MUL_RADIX4_EN
  localparam logic [4:0] LAST = 5'd15;
  localparam int unsigned MW = 33;
`else
  localparam logic [4:0] LAST = 5'd31;
  localparam int unsigned MW = 32;
`endif

  logic [4:0]    s_q, s_d;
  logic          u_q, u_d;
  logic [63:0]   mc_q, mc_d;
  logic [63:0]   acc_q, acc_d;
  logic [MW-1:0] mp_q, mp_d;

  logic          first, last, sgn;
  logic [63:0]   mc, acc, sum;
  logic [MW-1:0] mp;

  // Step 0 works straight from the ports; later steps use the captured copies.
  always_comb begin
    first = (s_q == 5'd0);
    last  = (s_q == LAST);
    sgn   = first ? ~u : ~u_q;
    if (first) begin
      mc = u ? {32'b0, x} : {{32{x[31]}}, x};
    end else begin
      mc = mc_q;
    end
    acc = first ? 64'd0 : acc_q;
  end

`ifdef MUL_RADIX4_EN
  logic [63:0] mag, xtra;
  logic        neg;

  always_comb begin
    mp  = first ? {y, 1'b0} : mp_q;
    neg = 1'b0;
    mag = 64'd0;
    case (mp[2:0])
      3'b001, 3'b010: mag = mc;
      3'b011:         mag = mc << 1;
      3'b100: begin
        mag = mc << 1;
        neg = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = mc;
        neg = 1'b1;
      end
      default: ;
    endcase
    // Unsigned top bit needs one more +1 digit at weight 2^32.
    xtra = (last && !sgn && mp[2]) ? (mc << 2) : 64'd0;
    sum  = acc + (neg ? -mag : mag) + xtra;
    mc_d = mc << 2;
    mp_d = mp >> 2;
  end
`else
  logic [63:0] pp;

  always_comb begin
    mp = first ? y : mp_q;
    pp = mp[0] ? mc : 64'd0;
    // Signed: y[31] carries weight -2^31.
    sum  = (last && sgn) ? (acc - pp) : (acc + pp);
    mc_d = mc << 1;
    mp_d = mp >> 1;
  end
`endif

  always_comb begin
    s_d   = 5'd0;
    u_d   = 1'b0;
    acc_d = 64'd0;
    if (run) begin
      s_d   = last ? 5'd0 : s_q + 5'd1;
      u_d   = first ? u : u_q;
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q   <= 5'd0;
      u_q   <= 1'b0;
      mc_q  <= 64'd0;
      mp_q  <= '0;
      acc_q <= 64'd0;
    end else begin
      s_q   <= s_d;
      u_q   <= u_d;
      mc_q  <= run ? mc_d : 64'd0;
      mp_q  <= run ? mp_d : '0;
      acc_q <= acc_d;
    end
  end

  assign stall = rst & run & ~last;
  assign z     = (rst & run & last) ? sum : 64'd0;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier.
// Honours MUL_RADIX4_EN to match the DUT build.
module tb_seq_multiplier;

`ifdef MUL_RADIX4_EN
  localparam int N = 16;
`else
  localparam int N = 32;
`endif
  localparam int SRST = (N > 20) ? 20 : N - 4;

  logic        clk;
  logic        rst;
  logic        run;
  logic        u;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [63:0] z;

  int n_cmp;
  int n_bad;

  seq_multiplier dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .u     (u),
    .x     (x),
    .y     (y),
    .stall (stall),
    .z     (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Call at a negedge with S=0; returns at a negedge.
  task automatic mul(input string tag, input logic uu, input logic [31:0] xx,
                     input logic [31:0] yy, input logic [63:0] exp,
                     input bit keep);
    int ns;
    ns  = 0;
    run = 1'b1;
    u   = uu;
    x   = xx;
    y   = yy;
    for (int i = 0; i < N; i++) begin
      #4;
      if (stall) ns++;
      if (i == N - 1) begin
        check({tag, " z"}, z, exp);
        check({tag, " stall@last"}, 64'(stall), 64'd0);
      end
      @(negedge clk);
      if (i == 0) begin
        u = ~uu;
        x = 32'h5A5A_1234;
        y = 32'hC3C3_8765;
      end
    end
    check({tag, " stall cycles"}, 64'(ns), 64'(N - 1));
    if (!keep) begin
      run = 1'b0;
      #4;
      check({tag, " z idle"}, z, 64'd0);
      check({tag, " stall idle"}, 64'(stall), 64'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    run = 1'b1;
    u   = 1'b1;
    x   = 32'hFFFF_FFFF;
    y   = 32'hFFFF_FFFF;
    #12;
    check("reset stall", 64'(stall), 64'd0);
    check("reset z", z, 64'd0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    mul("u ff*ff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'hFFFF_FFFE_0000_0001, 1'b0);
    mul("s -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        64'h0000_0000_0000_0001, 1'b0);
    mul("s -3*7", 1'b0, 32'hFFFF_FFFD, 32'd7,
        64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    mul("s min*min", 1'b0, 32'h8000_0000, 32'h8000_0000,
        64'h4000_0000_0000_0000, 1'b0);
    mul("u 2^31*2^31", 1'b1, 32'h8000_0000, 32'h8000_0000,
        64'h4000_0000_0000_0000, 1'b0);
    mul("u 12345*6789", 1'b1, 32'd12345, 32'd6789,
        64'd83810205, 1'b0);
    mul("s min*max", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF,
        64'hC000_0000_8000_0000, 1'b0);
    mul("u ff*2", 1'b1, 32'hFFFF_FFFF, 32'd2,
        64'h0000_0001_FFFF_FFFE, 1'b0);
    mul("s -1*2", 1'b0, 32'hFFFF_FFFF, 32'd2,
        64'hFFFF_FFFF_FFFF_FFFE, 1'b0);

    // Abort at S=10, then restart from S=0.
    run = 1'b1;
    u   = 1'b1;
    x   = 32'd1000;
    y   = 32'd1000;
    repeat (10) @(negedge clk);
    run = 1'b0;
    #4;
    check("abort stall", 64'(stall), 64'd0);
    check("abort z", z, 64'd0);
    @(negedge clk);
    mul("restart 6*7", 1'b1, 32'd6, 32'd7, 64'd42, 1'b0);

    // Back-to-back: run stays high across completion.
    mul("b2b 6*7", 1'b0, 32'd6, 32'd7, 64'd42, 1'b1);
    mul("b2b 3*5", 1'b0, 32'd3, 32'd5, 64'd15, 1'b0);

    // Asynchronous reset mid-operation.
    run = 1'b1;
    u   = 1'b1;
    x   = 32'd77;
    y   = 32'd88;
    repeat (SRST) @(negedge clk);
    #1;
    check("pre-rst stall", 64'(stall), 64'd1);
    rst = 1'b0;
    #1;
    check("async rst stall", 64'(stall), 64'd0);
    check("async rst z", z, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mul("post-rst 2*9", 1'b1, 32'd2, 32'd9, 64'd18, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
